// File: rtl/comet_ii_mem_arbiter_pkg.sv
// rtl/comet_ii_mem_arbiter_pkg.sv - shared types and constants for the Comet II RAM arbiter
package comet_ii_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  // Access sequencer: grant, strobe RAM, capture read data, pulse ack
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/comet_ii_mem_arbiter_if.sv
// rtl/comet_ii_mem_arbiter_if.sv - CPU, DMA and RAM port bundle for the arbiter
interface comet_ii_mem_arbiter_if #(
  parameter int AW = comet_ii_mem_pkg::AW_DEF,
  parameter int DW = comet_ii_mem_pkg::DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          owner;

  // Requesters and the RAM model sit on the master side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  owner
  );

  // The arbiter itself
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output owner
  );

endinterface

// File: rtl/comet_ii_mem_arbiter_fairness.sv
// rtl/comet_ii_mem_arbiter_fairness.sv - CPU-priority winner decision with anti-starvation counter
module comet_ii_arb_fairness #(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic i_mclk,
  input  logic i_rst,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  input  logic i_grant,
  output logic o_dma_wins
);

  localparam int CW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CPU_BURST);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CMAX);
  assign o_dma_wins = i_dma_req & (~i_cpu_req | w_at_limit);

  // Count CPU grants taken while DMA waits; any DMA grant or idle DMA clears it
  always_ff @(posedge i_mclk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_grant) begin
      if (o_dma_wins || !i_dma_req) begin
        r_count <= '0;
      end else if (!w_at_limit) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comet_ii_mem_arbiter.sv
// rtl/comet_ii_mem_arbiter.sv - shares one synchronous-read RAM port between CPU and DMA
module comet_ii_mem_arbiter
  import comet_ii_mem_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                   i_mclk,
  input  logic                   i_rst,
  comet_ii_mem_arbiter_if.slave  io_bus
);

  state_e        r_state;
  state_e        w_next_state;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;

  logic w_any_req;
  logic w_grant;
  logic w_dma_wins;
  logic w_ram_en;
  logic w_cpu_ack;
  logic w_dma_ack;

  assign w_any_req = io_bus.cpu_req | io_bus.dma_req;
  assign w_grant   = (r_state == IDLE) & w_any_req;

  comet_ii_arb_fairness #(
    .MAX_CPU_BURST(MAX_CPU_BURST)
  ) u_fairness (
    .i_mclk     (i_mclk),
    .i_rst      (i_rst),
    .i_cpu_req  (io_bus.cpu_req),
    .i_dma_req  (io_bus.dma_req),
    .i_grant    (w_grant),
    .o_dma_wins (w_dma_wins)
  );

  // State register
  always_ff @(posedge i_mclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-state strobes; each non-idle state lasts one cycle
  always_comb begin
    w_next_state = r_state;
    w_ram_en     = 1'b0;
    w_cpu_ack    = 1'b0;
    w_dma_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_next_state = ISSUE;
      end
      ISSUE: begin
        w_ram_en     = 1'b1;
        w_next_state = CAPTURE;
      end
      CAPTURE: begin
        w_next_state = ACK;
      end
      ACK: begin
        w_cpu_ack    = (r_owner == OWN_CPU);
        w_dma_ack    = (r_owner == OWN_DMA);
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Snapshot the winner's command at the grant edge so later input changes are ignored
  always_ff @(posedge i_mclk or negedge i_rst) begin
    if (!i_rst) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_dma_wins ? OWN_DMA : OWN_CPU;
      r_we    <= w_dma_wins ? io_bus.dma_we    : io_bus.cpu_we;
      r_addr  <= w_dma_wins ? io_bus.dma_addr  : io_bus.cpu_addr;
      r_wdata <= w_dma_wins ? io_bus.dma_wdata : io_bus.cpu_wdata;
    end
  end

  // Latch read data into the owner's holding register; writes leave both untouched
  always_ff @(posedge i_mclk or negedge i_rst) begin
    if (!i_rst) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else if ((r_state == CAPTURE) && !r_we) begin
      if (r_owner == OWN_DMA) begin
        r_dma_rdata <= io_bus.ram_rdata;
      end else begin
        r_cpu_rdata <= io_bus.ram_rdata;
      end
    end
  end

  assign io_bus.ram_en    = w_ram_en;
  assign io_bus.ram_we    = w_ram_en & r_we;
  assign io_bus.ram_addr  = r_addr;
  assign io_bus.ram_wdata = r_wdata;
  assign io_bus.cpu_ack   = w_cpu_ack;
  assign io_bus.dma_ack   = w_dma_ack;
  assign io_bus.cpu_rdata = r_cpu_rdata;
  assign io_bus.dma_rdata = r_dma_rdata;
  assign io_bus.owner     = r_owner;
  assign io_bus.cpu_stall = io_bus.cpu_req & ~w_cpu_ack;

endmodule

// File: doc/comet_ii_mem_arbiter.md
Name: comet_ii_mem_arbiter

Overview:
- Shares the CPU's single synchronous-read RAM port between two requesters:
  - the CPU bus, which the Comet II controller drives during IFETCH, operand and stack stages;
  - a DMA/loader port used for program load and I/O transfers.
- Sits between the CPU datapath and RAM.
- Drives a stall flag so the controller holds its current stage until its access completes.
- CPU has fixed priority, bounded by a fairness counter so DMA cannot starve.

Parameters:
- AW, 16, RAM address width.
- DW, 16, RAM data width.
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced; must be ≥ 1.

Ports:
- mclk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  hold-stage request to the controller
- dma_req  in  1  DMA request, held until dma_ack
- dma_we  in  1  DMA write enable
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  DMA read data, valid while dma_ack is high
- dma_ack  out  1  one-cycle completion pulse
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en
- owner  out  1  0 = CPU, 1 = DMA; current/last grant

Behaviour:
- Reset (rst = 0), asynchronous:
  - state = IDLE; owner = 0; fairness count = 0.
  - ram_en, ram_we, ram_addr, ram_wdata = 0.
  - cpu_ack, dma_ack = 0; cpu_rdata, dma_rdata = 0.
  - Reset mid-access drops the access. No ack is issued; requesters re-request.
- FSM states:
  - IDLE: no access in progress. At the clock edge, if any req is high, choose the winner, register owner/we/addr/wdata, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: ram_en = 1 for exactly this cycle; ram_we/ram_addr/ram_wdata come from the registers. Always go to CAPTURE.
  - CAPTURE: ram_rdata is valid. On a read, latch it into the owner's rdata register at the edge. Go to ACK.
  - ACK: the owner's ack = 1 for exactly this cycle. Always go to IDLE.
- Latency:
  - Request first sampled high at the end of cycle 0 → ram_en in cycle 1 → ack in cycle 3.
  - Minimum spacing between accesses is 4 cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until its ack. The arbiter samples them only at the grant edge.
  - Requester drops req, or presents the next request, at the edge ending its ack cycle.
  - req is ignored outside IDLE.
  - Writes follow the same sequence; the rdata registers are unchanged on writes.
  - rdata holds its value after ack until the next read by the same owner.
- Arbitration (IDLE only):
  - Only one req high → that requester wins.
  - Both high → CPU wins, unless count == MAX_CPU_BURST; then DMA wins.
- Fairness count, updated at the grant edge:
  - CPU grant with dma_req high → count + 1, saturating at MAX_CPU_BURST.
  - CPU grant with dma_req low → count = 0.
  - DMA grant → count = 0.
- cpu_stall = cpu_req & ~(state == ACK & owner == CPU), combinational.
  - It is also high while DMA owns the port.
- Never assert ram_en while rst is low. Never assert both acks in the same cycle.

Decomposition:
- Shared package comet_ii_mem_pkg holds:
  - the state enum {IDLE, ISSUE, CAPTURE, ACK};
  - the owner encoding constants OWN_CPU = 0 and OWN_DMA = 1;
  - AW and DW defaults.
- One sub-module: comet_ii_arb_fairness.
  - Contains the saturating counter and the winner decision.
  - Inputs: cpu_req, dma_req, grant strobe. Output: dma_wins.

Test Plan:
- CPU read: preload RAM[0x0010] = 0xABCD; cpu_req = 1, cpu_we = 0, cpu_addr = 0x0010 → ram_en only in cycle 1; cpu_ack in cycle 3 with cpu_rdata = 0xABCD; cpu_stall high in cycles 0–2, low in cycle 3.
- DMA write then CPU read: dma write 0x1234 to 0x0020, then CPU reads 0x0020 → dma_ack once; RAM[0x0020] = 0x1234; cpu_rdata = 0x1234; dma_rdata unchanged.
- Contention: both requesters continuous, MAX_CPU_BURST = 4 → grant order CPU, CPU, CPU, CPU, DMA, repeating; owner toggles accordingly.
- CPU only, with dma_req low for 10 requests → count stays 0; all grants go to CPU; back-to-back spacing is exactly 4 cycles.
- Reset mid-access: drop rst during CAPTURE of a CPU read → all outputs 0 immediately; no cpu_ack; after release, re-request completes normally.
- Address changed after grant: CPU changes cpu_addr during ISSUE → ram_addr keeps the value sampled at the grant edge.
